// File: rtl/totient_pkg.sv
// Shared types and helpers for the Euler totient engine.
// Latency: n/a (types, constants and a pure combinational function).
// Backpressure: n/a.
package totient_pkg;

    // Default operand width
    localparam int W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        GCD   = 3'd2,
        ACCUM = 3'd3,
        FIN   = 3'd4
    } state_t;

    // Hex digit to seven-segment pattern, bit 6 = A ... bit 0 = G, active-high
    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/gcd_sub.sv
// Subtractive GCD: repeatedly reduces the larger operand by the smaller until equal.
// Latency: 1 load cycle + 1 cycle per subtraction + 1 cycle to raise rdy.
// Backpressure: none; a new go restarts the unit, rdy is a one-cycle pulse, g holds until next result.
//
// Ports: clk_0 clock, R async active-low reset, go loads a/b (both >= 1),
//        rdy one-cycle result strobe, g the gcd (valid from rdy until the next rdy).
module gcd_sub #(
    parameter int W = 8
) (
    input  logic         clk_0,
    input  logic         R,
    input  logic         go,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         rdy,
    output logic [W-1:0] g
);

    logic [W-1:0] a_r;
    logic [W-1:0] b_r;
    logic         run;

    always_ff @(posedge clk_0 or negedge R) begin
        if (!R) begin
            a_r <= '0;
            b_r <= '0;
            run <= 1'b0;
            rdy <= 1'b0;
            g   <= '0;
        end else begin
            rdy <= 1'b0;
            if (go) begin
                a_r <= a;
                b_r <= b;
                run <= 1'b1;
            end else if (run) begin
                if (a_r == b_r) begin
                    run <= 1'b0;
                    rdy <= 1'b1;
                    g   <= a_r;
                end else if (a_r > b_r) begin
                    a_r <= a_r - b_r;
                end else begin
                    b_r <= b_r - a_r;
                end
            end
        end
    end

endmodule

// File: rtl/euler_totient_seq.sv
// Euler totient engine: phi(n) = count of k in 1..n with gcd(k,n)==1, shown as hex on 7-seg digits.
// Latency: IDLE exit to done <= n*(n+4)+3 cycles; n=0 takes 3 cycles.
// Backpressure: start is dropped while busy; results hold until the next done pulse.
//
// Ports: clk_0 clock, R async active-low reset, mode (0 auto sequence, 1 single-shot),
//        start/n_in single-shot request and operand, busy in-progress flag, done result strobe,
//        n_out/phi last result, seg D hex digits of phi (digit i at seg[7i+6:7i]), blank after reset.
module euler_totient_seq
    import totient_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int N_MAX = (1 << W) - 1,
    parameter int D     = (W + 3) / 4
) (
    input  logic           clk_0,
    input  logic           R,
    input  logic           mode,
    input  logic           start,
    input  logic [W-1:0]   n_in,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   n_out,
    output logic [W-1:0]   phi,
    output logic [7*D-1:0] seg
);

    localparam logic [W-1:0] N_WRAP = W'(N_MAX);
    localparam logic [W-1:0] ONE    = W'(1);
    localparam int           PW     = 4 * D;

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] n_r;
    logic [W-1:0] k_r;
    logic [W-1:0] cnt_r;
    logic [W-1:0] auto_n;
    logic         shown;
    logic         gcd_go;
    logic [W-1:0] gcd_a;
    logic         gcd_rdy;
    logic [W-1:0] gcd_g;

    gcd_sub #(.W(W)) u_gcd (
        .clk_0 (clk_0),
        .R     (R),
        .go    (gcd_go),
        .a     (gcd_a),
        .b     (n_r),
        .rdy   (gcd_rdy),
        .g     (gcd_g)
    );

    always_ff @(posedge clk_0 or negedge R) begin
        if (!R) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The gcd unit is launched in the same cycle k advances, so its operand is
    // the upcoming k: 1 from LOAD, k+1 from ACCUM (k < n there, so no overflow).
    always_comb begin
        state_nxt = state;
        gcd_go    = 1'b0;
        gcd_a     = k_r + ONE;
        case (state)
            IDLE: begin
                if (!mode || start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                gcd_a = ONE;
                if (n_r == '0) begin
                    state_nxt = FIN;
                end else begin
                    gcd_go    = 1'b1;
                    state_nxt = GCD;
                end
            end
            GCD: begin
                if (gcd_rdy) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (k_r == n_r) begin
                    state_nxt = FIN;
                end else begin
                    gcd_go    = 1'b1;
                    state_nxt = GCD;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_0 or negedge R) begin
        if (!R) begin
            n_r    <= '0;
            k_r    <= '0;
            cnt_r  <= '0;
            auto_n <= ONE;
            busy   <= 1'b0;
            done   <= 1'b0;
            n_out  <= '0;
            phi    <= '0;
            shown  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!mode) begin
                        n_r    <= auto_n;
                        auto_n <= (auto_n == N_WRAP) ? ONE : auto_n + ONE;
                        busy   <= 1'b1;
                    end else if (start) begin
                        n_r  <= n_in;
                        busy <= 1'b1;
                    end
                end
                LOAD: begin
                    k_r   <= ONE;
                    cnt_r <= '0;
                end
                ACCUM: begin
                    if (gcd_g == ONE) begin
                        cnt_r <= cnt_r + ONE;
                    end
                    if (k_r != n_r) begin
                        k_r <= k_r + ONE;
                    end
                end
                FIN: begin
                    n_out <= n_r;
                    phi   <= cnt_r;
                    shown <= 1'b1;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Digits stay blank until the first result after reset.
    logic [PW-1:0] phi_pad;
    assign phi_pad = PW'(phi);

    for (genvar i = 0; i < D; i++) begin : g_dig
        assign seg[7*i +: 7] = shown ? hex7(phi_pad[4*i +: 4]) : 7'b0000000;
    end

endmodule

// File: doc/euler_totient_seq.md
# euler_totient_seq

Parametrised Euler totient engine that computes φ(n) for W-bit n by counting the k in 1..n with gcd(k,n)=1, using an iterative subtractive-GCD datapath. It replaces the fixed-width free-running totient display generator. It adds a single-shot mode with a start/done handshake, a configurable wrap point for auto-sequencing, and a multi-digit hex seven-segment output. It sits between the board clock/reset and the seven-segment display bank.

## Interface
- W, 8: width of n, k, counter and φ
- N_MAX, 2**W-1: last n in auto mode before wrap to 1 (1 ≤ N_MAX ≤ 2**W-1)
- D, (W+3)/4: number of hex display digits
- clk_0  in  1  single clock, rising edge
- R  in  1  reset, asynchronous, active-low
- mode  in  1  0 = auto sequence n=1,2,…; 1 = single-shot on start
- start  in  1  single-shot request, ignored when mode=0 or busy=1
- n_in  in  W  operand for single-shot, sampled on accepted start
- busy  out  1  computation in progress
- done  out  1  one-cycle pulse when phi/n_out/seg update
- n_out  out  W  n of the currently displayed result
- phi  out  W  φ(n_out)
- seg  out  7*D  hex of phi; digit i at seg[7i+6:7i]; bit 6=A … bit 0=G, active-high

## Operation
- FSM states: IDLE, LOAD, GCD, ACCUM, FIN.
- IDLE:
  - mode=0: go to LOAD with n = next auto value (1 after reset, then n+1, wrapping from N_MAX to 1).
  - mode=1 and start=1: latch n_in and go to LOAD.
  - mode is sampled only in IDLE.
- LOAD:
  - n=0: go to FIN with count=0.
  - Otherwise k=1, count=0, pulse gcd go, go to GCD.
- GCD: wait for gcd_rdy, then go to ACCUM.
- ACCUM:
  - count += (g==1).
  - If k==n, go to FIN.
  - Else k+1, pulse go, return to GCD.
- FIN: register n_out=n, phi=count, seg=hex(count); pulse done; go to IDLE.
- Outputs hold their last result between done pulses.
- Arithmetic:
  - count ≤ n, so no overflow at W bits.
  - k and n compare at full W width; k never exceeds n.
- start while busy=1 is dropped, not queued. Changes on n_in after acceptance have no effect.
- Hex patterns (ABCDEFG), all 16 required:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111

## Timing
- Reset (R=0), asynchronous and also mid-computation:
  - Outputs: busy=0, done=0, n_out=0, phi=0, seg=all zeros (blank).
  - Internals: FSM=IDLE, auto n restarts at 1.
- busy:
  - Rises the cycle after IDLE exits; falls in the cycle done is high.
  - done and the new phi/seg are visible in the same cycle.
- gcd_sub latency:
  - 1 load cycle, plus one cycle per subtraction, plus 1 ready cycle.
  - Per k, latency is ≤ n+2 cycles.
- Total latency from IDLE exit to done ≤ n·(n+4)+3 cycles. n=0 completes in 3 cycles.
- Auto mode: the next LOAD starts the cycle after done.

## Structure
- Package totient_pkg holds:
  - the FSM state enum
  - function hex7(input [3:0]) returning the ABCDEFG pattern
  - default W
- Sub-module gcd_sub #(W):
  - Ports: clk_0, R, go, a, b, rdy, g.
  - While a≠b, the larger operand is reduced by the smaller; g=a when they are equal.
  - Inputs a, b ≥ 1 are guaranteed by the caller.
- Top instantiates one gcd_sub and D hex7 lookups driven from the registered phi.

## Test plan
- Reset: assert R=0 mid-GCD at n=7 → busy, done, n_out, phi and seg all 0 immediately, without waiting for a clock edge. Release → auto restarts at n=1.
- Auto, W=8: done sequence yields φ for n=1..10 = 1,1,2,2,4,2,6,4,6,4. seg[6:0] for φ=6 is 1011111.
- Wrap: N_MAX=12 → after n=12 (φ=4), next done shows n_out=1, φ=1.
- Single-shot:
  - n_in=0 → phi=0 in 3 cycles.
  - n_in=1 → 1.
  - n_in=97 → 96 (0x60).
  - n_in=255 → 128, with seg = 1111111_1111110 (digit 1 then digit 0).
- Handshake: start pulsed while busy with n_in=5 is ignored. Next accepted start with n_in=9 → φ=6. Exactly one done pulse per accepted start. Latency stays within the bound.
- W=12, single-shot n_in=1000 → phi=400 (0x190), shown as three digits 1,9,0.
